dma_ctrl: RTL and testbench
===========================

Name: dma_ctrl

Overview:
- Sits between the nn core's DMA port and a single-ported external DRAM.
- Translates nn's 5-bit local read/write addresses into 10-bit DRAM addresses by adding configurable bases.
- Buffers nn writes in a small FIFO and arbitrates reads and buffered writes onto one request/ack memory port.
- Returns read data to nn through a ready/valid handshake.

Parameters:
- WBUF_DEPTH, 4: write-buffer entries, power of two, 2..16.
- AW, 10: DRAM address width.
- DW, 8: data width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous active-low reset.
- i_rd_base  in  AW  DRAM base added to nn read addresses; sampled when a read is accepted.
- i_wr_base  in  AW  DRAM base added to nn write addresses; sampled when a write is pushed.
- i_nn_rd_en  in  1  nn read request.
- i_nn_rd_addr  in  5  nn local read address.
- o_nn_rd_ready  out  1  read request may be accepted this cycle.
- o_nn_rd_data  out  DW  read data; held stable until the next read completes.
- o_nn_rd_valid  out  1  one-cycle pulse, o_nn_rd_data is new.
- i_nn_wr_en  in  1  nn write strobe.
- i_nn_wr_addr  in  5  nn local write address.
- i_nn_wr_data  in  DW  nn write data.
- o_wbuf_full  out  1  write FIFO holds WBUF_DEPTH entries.
- o_wr_overflow  out  1  sticky: a write was dropped because the FIFO was full.
- o_mem_en  out  1  memory request.
- o_mem_we  out  1  1 = write, 0 = read.
- o_mem_addr  out  AW  memory address.
- o_mem_wdata  out  DW  memory write data.
- i_mem_rdata  in  DW  memory read data; valid in the cycle i_mem_ack is high for a read.
- i_mem_ack  in  1  request completes this cycle.

Behaviour:
- Reset (asynchronous, i_rst=0): clears all outputs, FIFO pointers and count, the pending-read flag, the overflow flag and the FSM, independent of the clock.
  - Any in-flight memory request is abandoned: o_mem_en falls immediately.
  - An ack arriving after reset release with no request outstanding is ignored.
- Address arithmetic: address = base + zero-extended 5-bit address, modulo 2^AW. Example: 1020+7 gives 3; no carry out.
- Read accept:
  - o_nn_rd_ready = !rd_pend.
  - A read is accepted on a clock edge where i_nn_rd_en and o_nn_rd_ready are both 1; the block latches the computed address and sets rd_pend.
  - o_nn_rd_ready is 0 from the next cycle until the read's ack cycle.
- Write push:
  - On i_nn_wr_en, the entry {address, data} is pushed if the registered count is below WBUF_DEPTH.
  - Otherwise the write is dropped and o_wr_overflow is set until reset.
  - A pop in the same cycle does not free space for that push: there is no bypass.
  - o_wbuf_full = (count == WBUF_DEPTH).
- FSM, states IDLE, RD, WR:
  - IDLE: if the FIFO is full, go to WR with the head entry. Else if rd_pend, go to RD. Else if the FIFO is non-empty, go to WR. Else stay in IDLE.
  - A decision is taken on the edge and the request is driven from the next cycle. A read accepted in cycle N is therefore issued no earlier than N+1.
  - RD: o_mem_en=1, o_mem_we=0, o_mem_addr = the latched read address, all held until i_mem_ack.
    - On ack: capture i_mem_rdata into o_nn_rd_data, pulse o_nn_rd_valid in the next cycle, clear rd_pend, return to IDLE.
  - WR: o_mem_en=1, o_mem_we=1, address and data from the FIFO head, held until i_mem_ack.
    - On ack: pop the head, return to IDLE.
  - Request fields never change while o_mem_en=1 and no ack has been seen.
  - o_mem_en is 0 in IDLE, so back-to-back transactions are separated by at least one idle cycle.
- Latency: with an ack in the first request cycle, a read accepted at edge N drives o_nn_rd_valid in cycle N+3.
- Ordering:
  - Writes reach memory in FIFO order.
  - A read may overtake buffered writes; nn does not read an address it has buffered writes to until o_wbuf_full=0 and the FIFO has drained. Enforcing this is the software's responsibility.
- Simultaneous events:
  - A push and a pop in the same cycle leave count unchanged. The push is accepted only if count < WBUF_DEPTH before the edge.
  - i_nn_rd_en while rd_pend is ignored; no second read is queued.
- i_mem_ack in IDLE is ignored.

Test Plan:
- Reset mid-read: i_rst low while in RD with o_mem_en=1 -> o_mem_en=0 immediately and o_nn_rd_ready=1 after release. An ack at release produces no o_nn_rd_valid.
- Single read: i_rd_base=100, rd_addr=5, memory acks the first request cycle with 0x3C -> o_mem_addr=105, o_mem_we=0; o_nn_rd_data=0x3C with o_nn_rd_valid pulsed in cycle N+3; ready low from N+1 to N+2.
- Write burst: i_wr_base=200, 4 writes to addr 0..3 with data 0xA0..0xA3, memory stalls ack for 10 cycles -> o_wbuf_full=1 after the 4th push. A 5th write sets o_wr_overflow. Writes then appear at addresses 200..203 in order, and o_wbuf_full falls after the first ack.
- Priority: FIFO holds 2 entries (not full) and a read is pending -> the read is issued before either write. With the FIFO full and a read pending -> a write is issued first.
- Address wrap: i_rd_base=1020, rd_addr=7 -> o_mem_addr=3.
- Held request: ack delayed 5 cycles during WR -> o_mem_en, o_mem_we, o_mem_addr and o_mem_wdata stable for all 5 cycles; the pop occurs only on the ack edge.

Source files
------------

// File: rtl/dma_ctrl.sv
// DMA bridge between the nn core and a single-ported DRAM: base-offset address
// translation, a small write buffer, and read/write arbitration onto one req/ack port.
module dma_ctrl #(
    parameter int WBUF_DEPTH = 4,
    parameter int AW         = 10,
    parameter int DW         = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [AW-1:0] i_rd_base,
    input  logic [AW-1:0] i_wr_base,
    input  logic          i_nn_rd_en,
    input  logic [4:0]    i_nn_rd_addr,
    output logic          o_nn_rd_ready,
    output logic [DW-1:0] o_nn_rd_data,
    output logic          o_nn_rd_valid,
    input  logic          i_nn_wr_en,
    input  logic [4:0]    i_nn_wr_addr,
    input  logic [DW-1:0] i_nn_wr_data,
    output logic          o_wbuf_full,
    output logic          o_wr_overflow,
    output logic          o_mem_en,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata,
    input  logic          i_mem_ack
);
    localparam int            PW      = $clog2(WBUF_DEPTH);
    localparam int            CW      = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(WBUF_DEPTH);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t        state_reg;
    logic [AW-1:0] fifo_addr [WBUF_DEPTH];
    logic [DW-1:0] fifo_data [WBUF_DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          rd_pend_reg;
    logic [AW-1:0] rd_addr_reg;

    logic          push;
    logic          pop;
    logic          rd_accept;
    logic [AW-1:0] rd_addr_calc;
    logic [AW-1:0] wr_addr_calc;

    // Address sums wrap modulo 2^AW; the carry out is deliberately discarded.
    assign rd_addr_calc  = i_rd_base + AW'(i_nn_rd_addr);
    assign wr_addr_calc  = i_wr_base + AW'(i_nn_wr_addr);

    // Space is judged on the registered count, so a same-cycle pop never frees room.
    assign push          = i_nn_wr_en && (count_reg < DEPTH_C);
    assign pop           = (state_reg == WR) && i_mem_ack;
    assign rd_accept     = i_nn_rd_en && !rd_pend_reg;
    assign o_nn_rd_ready = !rd_pend_reg;
    assign o_wbuf_full   = (count_reg == DEPTH_C);

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_addr[wr_ptr_reg] <= wr_addr_calc;
            fifo_data[wr_ptr_reg] <= i_nn_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_reg     <= IDLE;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            rd_pend_reg   <= 1'b0;
            rd_addr_reg   <= '0;
            o_nn_rd_data  <= '0;
            o_nn_rd_valid <= 1'b0;
            o_wr_overflow <= 1'b0;
            o_mem_en      <= 1'b0;
            o_mem_we      <= 1'b0;
            o_mem_addr    <= '0;
            o_mem_wdata   <= '0;
        end else begin
            o_nn_rd_valid <= 1'b0;

            if (push)
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            if (push && !pop)
                count_reg <= count_reg + CW'(1);
            else if (!push && pop)
                count_reg <= count_reg - CW'(1);

            if (i_nn_wr_en && !push)
                o_wr_overflow <= 1'b1;

            if (rd_accept) begin
                rd_pend_reg <= 1'b1;
                rd_addr_reg <= rd_addr_calc;
            end

            case (state_reg)
                IDLE: begin
                    // A full buffer outranks a pending read so nn writes are not stalled forever.
                    if (o_wbuf_full || (!rd_pend_reg && count_reg != '0)) begin
                        state_reg   <= WR;
                        o_mem_en    <= 1'b1;
                        o_mem_we    <= 1'b1;
                        o_mem_addr  <= fifo_addr[rd_ptr_reg];
                        o_mem_wdata <= fifo_data[rd_ptr_reg];
                    end else if (rd_pend_reg) begin
                        state_reg  <= RD;
                        o_mem_en   <= 1'b1;
                        o_mem_we   <= 1'b0;
                        o_mem_addr <= rd_addr_reg;
                    end
                end
                RD: begin
                    if (i_mem_ack) begin
                        state_reg     <= IDLE;
                        o_mem_en      <= 1'b0;
                        o_nn_rd_data  <= i_mem_rdata;
                        o_nn_rd_valid <= 1'b1;
                        rd_pend_reg   <= 1'b0;
                    end
                end
                WR: begin
                    if (i_mem_ack) begin
                        state_reg <= IDLE;
                        o_mem_en  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    o_mem_en  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dma_ctrl.sv
// Bench for dma_ctrl: a behavioural model predicts memory traffic, read data and
// status flags; a negedge monitor pops expected items whenever the DUT presents them.
`timescale 1ns/1ps
module tb_dma_ctrl;
    localparam int D  = 4;
    localparam int AW = 10;
    localparam int DW = 8;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b0;
    logic [AW-1:0] i_rd_base = '0;
    logic [AW-1:0] i_wr_base = '0;
    logic          i_nn_rd_en = 1'b0;
    logic [4:0]    i_nn_rd_addr = '0;
    logic          o_nn_rd_ready;
    logic [DW-1:0] o_nn_rd_data;
    logic          o_nn_rd_valid;
    logic          i_nn_wr_en = 1'b0;
    logic [4:0]    i_nn_wr_addr = '0;
    logic [DW-1:0] i_nn_wr_data = '0;
    logic          o_wbuf_full;
    logic          o_wr_overflow;
    logic          o_mem_en;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic [DW-1:0] i_mem_rdata = '0;
    logic          i_mem_ack = 1'b0;

    dma_ctrl #(.WBUF_DEPTH(D), .AW(AW), .DW(DW)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_rd_base(i_rd_base), .i_wr_base(i_wr_base),
        .i_nn_rd_en(i_nn_rd_en), .i_nn_rd_addr(i_nn_rd_addr),
        .o_nn_rd_ready(o_nn_rd_ready), .o_nn_rd_data(o_nn_rd_data), .o_nn_rd_valid(o_nn_rd_valid),
        .i_nn_wr_en(i_nn_wr_en), .i_nn_wr_addr(i_nn_wr_addr), .i_nn_wr_data(i_nn_wr_data),
        .o_wbuf_full(o_wbuf_full), .o_wr_overflow(o_wr_overflow),
        .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack)
    );

    always #5 i_clk = ~i_clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        tests++;
        fails++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference model state
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic [DW-1:0] mem_m [1 << AW];
    wr_t           exp_wr_q[$];
    logic [AW-1:0] exp_rd_addr_q[$];
    logic [DW-1:0] exp_rd_data_q[$];
    int            op_log[$];   // 1 = write completed, 0 = read completed
    int            cnt_m = 0;
    bit            pend_m = 0;
    bit            ovf_m = 0;
    bit            valid_due_m = 0;
    logic [DW-1:0] hold_m = '0;
    logic [AW-1:0] last_rd_addr_m = '0;
    bit            prev_hold = 0;
    bit            prev_acked = 0;
    logic          prev_we = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_wdata = '0;

    // Memory responder
    int ack_delay_cfg = 0;     // -1 selects a random 0..3 stall per request
    bit idle_ack = 0;
    int wait_cnt = 0;
    int cur_delay = 0;

    always @(negedge i_clk) begin
        if (o_mem_en) begin
            i_mem_rdata = mem_m[o_mem_addr];
            if (wait_cnt >= cur_delay) begin
                i_mem_ack = 1'b1;
                wait_cnt  = 0;
            end else begin
                i_mem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            i_mem_ack   = idle_ack;
            i_mem_rdata = DW'($urandom);
            wait_cnt    = 0;
            cur_delay   = (ack_delay_cfg < 0) ? int'($urandom_range(0, 3)) : ack_delay_cfg;
        end
    end

    // Model + monitor: check the current cycle, then apply what the next edge will do
    always @(negedge i_clk) begin : monitor
        bit            ack_now;
        bit            pop_m;
        bit            push_m;
        bit            pend_cur;
        wr_t           w;
        logic [AW-1:0] ra;
        #1;
        if (!i_rst) begin
            cnt_m = 0; pend_m = 0; ovf_m = 0; valid_due_m = 0; hold_m = '0;
            exp_wr_q.delete(); exp_rd_addr_q.delete(); exp_rd_data_q.delete();
            prev_hold = 0; prev_acked = 0;
        end else begin
            chk("rd_ready", o_nn_rd_ready, !pend_m);
            chk("wbuf_full", o_wbuf_full, cnt_m == D);
            chk("wr_overflow", o_wr_overflow, ovf_m);
            chk("rd_valid", o_nn_rd_valid, valid_due_m);
            if (valid_due_m) begin
                if (exp_rd_data_q.size() == 0) flag("rd_data_unexpected");
                else hold_m = exp_rd_data_q.pop_front();
            end
            chk("rd_data", o_nn_rd_data, hold_m);
            valid_due_m = 0;

            if (prev_hold) begin
                chk("held_en", o_mem_en, 1);
                chk("held_we", o_mem_we, prev_we);
                chk("held_addr", o_mem_addr, prev_addr);
                if (prev_we) chk("held_wdata", o_mem_wdata, prev_wdata);
            end
            if (prev_acked) chk("idle_gap", o_mem_en, 0);

            ack_now  = o_mem_en && i_mem_ack;
            pop_m    = 0;
            pend_cur = pend_m;
            if (ack_now && o_mem_we) begin
                if (exp_wr_q.size() == 0) flag("mem_write_unexpected");
                else begin
                    w = exp_wr_q.pop_front();
                    chk("mem_wr_addr", o_mem_addr, w.addr);
                    chk("mem_wr_data", o_mem_wdata, w.data);
                end
                pop_m = 1;
                op_log.push_back(1);
            end else if (ack_now) begin
                if (exp_rd_addr_q.size() == 0) flag("mem_read_unexpected");
                else chk("mem_rd_addr", o_mem_addr, exp_rd_addr_q.pop_front());
                last_rd_addr_m = o_mem_addr;
                pend_m      = 0;
                valid_due_m = 1;
                op_log.push_back(0);
            end

            push_m = 0;
            if (i_nn_wr_en) begin
                if (cnt_m < D) begin
                    w.addr = AW'((int'(i_wr_base) + int'(i_nn_wr_addr)) % (1 << AW));
                    w.data = i_nn_wr_data;
                    exp_wr_q.push_back(w);
                    push_m = 1;
                end else begin
                    ovf_m = 1;
                end
            end
            if (i_nn_rd_en && !pend_cur) begin
                ra = AW'((int'(i_rd_base) + int'(i_nn_rd_addr)) % (1 << AW));
                exp_rd_addr_q.push_back(ra);
                exp_rd_data_q.push_back(mem_m[ra]);
                pend_m = 1;
            end
            cnt_m = cnt_m + int'(push_m) - int'(pop_m);

            prev_hold  = o_mem_en && !i_mem_ack;
            prev_acked = ack_now;
            prev_we    = o_mem_we;
            prev_addr  = o_mem_addr;
            prev_wdata = o_mem_wdata;
        end
    end

    task automatic rd(input logic [4:0] a);
        i_nn_rd_en = 1'b1; i_nn_rd_addr = a;
        @(posedge i_clk); #1;
        i_nn_rd_en = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [DW-1:0] d);
        i_nn_wr_en = 1'b1; i_nn_wr_addr = a; i_nn_wr_data = d;
        @(posedge i_clk); #1;
        i_nn_wr_en = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while ((exp_wr_q.size() != 0 || pend_m || valid_due_m || o_mem_en) && k < 400) begin
            @(negedge i_clk); #2;
            k++;
        end
        if (k >= 400) flag({name, "_drain_timeout"});
        @(posedge i_clk); #1;
    endtask

    task automatic wait_ops(input int n, input string name);
        int k;
        k = 0;
        while (op_log.size() < n && k < 200) begin
            @(negedge i_clk); #2;
            k++;
        end
        if (k >= 200) flag({name, "_timeout"});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        int n;
        bit got;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;

        for (int i = 0; i < (1 << AW); i++) mem_m[i] = DW'($urandom);
        mem_m[105] = 8'h3C;

        // Reset state
        repeat (3) @(negedge i_clk);
        #2;
        chk("rst_mem_en", o_mem_en, 0);
        chk("rst_mem_we", o_mem_we, 0);
        chk("rst_mem_addr", o_mem_addr, 0);
        chk("rst_mem_wdata", o_mem_wdata, 0);
        chk("rst_rd_valid", o_nn_rd_valid, 0);
        chk("rst_rd_data", o_nn_rd_data, 0);
        chk("rst_full", o_wbuf_full, 0);
        chk("rst_overflow", o_wr_overflow, 0);
        chk("rst_ready", o_nn_rd_ready, 1);
        #1 i_rst = 1'b1;
        @(posedge i_clk); #1;

        // Single read with latency check
        ack_delay_cfg = 0;
        i_rd_base = AW'(100);
        rd(5'd5);
        got = 0;
        k = 0;
        while (!got && k < 20) begin
            @(negedge i_clk); #2;
            k++;
            if (k <= 2) chk("single_ready_low", o_nn_rd_ready, 0);
            if (o_mem_en && !o_mem_we) chk("single_mem_addr", o_mem_addr, 105);
            if (o_nn_rd_valid) begin
                got = 1;
                chk("single_latency", k, 3);
                chk("single_data", o_nn_rd_data, 8'h3C);
            end
        end
        if (!got) flag("single_read_timeout");
        wait_drain("single");
        $display("[TB] single read done");

        // Address wrap
        i_rd_base = AW'(1020);
        rd(5'd7);
        wait_drain("wrap");
        chk("wrap_addr", last_rd_addr_m, 3);
        $display("[TB] wrap read done");

        // Write burst with stalled memory
        ack_delay_cfg = 10;
        i_wr_base = AW'(200);
        for (int i = 0; i < 4; i++) begin
            i_nn_wr_en = 1'b1; i_nn_wr_addr = 5'(i); i_nn_wr_data = 8'hA0 + 8'(i);
            @(posedge i_clk); #1;
        end
        i_nn_wr_en = 1'b0;
        chk("burst_full", o_wbuf_full, 1);
        chk("burst_no_overflow_yet", o_wr_overflow, 0);
        wr(5'd4, 8'hA4);
        chk("burst_overflow", o_wr_overflow, 1);
        k = 0;
        while (o_wbuf_full && k < 50) begin @(negedge i_clk); #2; k++; end
        if (k >= 50) flag("burst_full_stuck");
        chk("burst_count_after_first_ack", op_log.size() > 0, 1);
        wait_drain("burst");
        $display("[TB] write burst done");

        // Held write request, ack after 5 stall cycles
        ack_delay_cfg = 5;
        i_wr_base = AW'(300);
        wr(5'd9, 8'h77);
        k = 0;
        while (!o_mem_en && k < 20) begin @(negedge i_clk); #2; k++; end
        a0 = o_mem_addr;
        d0 = o_mem_wdata;
        chk("held_first_addr", a0, 309);
        chk("held_first_data", d0, 8'h77);
        n = 0;
        while (o_mem_en && n < 40) begin
            chk("held_stable_addr", o_mem_addr, a0);
            chk("held_stable_data", o_mem_wdata, d0);
            n++;
            @(negedge i_clk); #2;
        end
        chk("held_req_cycles", n, 6);
        wait_drain("held");
        $display("[TB] held write done");

        // Priority: 2 buffered writes vs pending read -> read first
        ack_delay_cfg = 6;
        op_log.delete();
        wr(5'd0, 8'h11);
        wr(5'd1, 8'h12);
        wr(5'd2, 8'h13);
        i_rd_base = AW'(700);
        rd(5'd1);
        wait_ops(2, "prio1");
        if (op_log.size() >= 2) begin
            chk("prio1_first_write", op_log[0], 1);
            chk("prio1_read_before_writes", op_log[1], 0);
        end
        wait_drain("prio1");
        $display("[TB] priority (not full) done");

        // Priority: full buffer vs freshly requested read -> write first
        op_log.delete();
        rd(5'd3);
        for (int i = 0; i < 4; i++) wr(5'(i + 8), 8'h50 + 8'(i));
        wait_ops(1, "prio2_rd");
        @(posedge i_clk); #1;
        rd(5'd4);
        wait_ops(3, "prio2");
        if (op_log.size() >= 3) begin
            chk("prio2_first_read", op_log[0], 0);
            chk("prio2_write_first_when_full", op_log[1], 1);
            chk("prio2_then_read", op_log[2], 0);
        end
        wait_drain("prio2");
        $display("[TB] priority (full) done");

        // Ack while idle is ignored
        ack_delay_cfg = 0;
        @(negedge i_clk); #2;
        idle_ack = 1;
        repeat (5) @(negedge i_clk);
        #2 idle_ack = 0;
        chk("idle_ack_no_mem_en", o_mem_en, 0);
        @(posedge i_clk); #1;
        $display("[TB] idle ack done");

        // Randomised traffic
        ack_delay_cfg = -1;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 15) == 0) begin
                i_rd_base = AW'($urandom_range(600, 1023));
                i_wr_base = AW'($urandom_range(100, 400));
            end
            i_nn_rd_en   = ($urandom_range(0, 99) < 30);
            i_nn_rd_addr = 5'($urandom);
            i_nn_wr_en   = ($urandom_range(0, 99) < 40);
            i_nn_wr_addr = 5'($urandom);
            i_nn_wr_data = DW'($urandom);
            @(posedge i_clk); #1;
        end
        i_nn_rd_en = 1'b0;
        i_nn_wr_en = 1'b0;
        wait_drain("random");
        $display("[TB] random traffic done");

        // Reset during an in-flight read
        ack_delay_cfg = 20;
        i_rd_base = AW'(800);
        rd(5'd9);
        k = 0;
        while (!o_mem_en && k < 20) begin @(negedge i_clk); #2; k++; end
        chk("rstmid_in_flight", o_mem_en, 1);
        @(negedge i_clk); #3;
        i_rst = 1'b0;
        #1;
        chk("rstmid_mem_en_async", o_mem_en, 0);
        chk("rstmid_ready_async", o_nn_rd_ready, 1);
        chk("rstmid_overflow_cleared", o_wr_overflow, 0);
        idle_ack = 1;
        repeat (2) @(negedge i_clk);
        #3 i_rst = 1'b1;
        repeat (4) @(negedge i_clk);
        #2 idle_ack = 0;
        chk("rstmid_ready_after", o_nn_rd_ready, 1);
        chk("rstmid_no_valid", o_nn_rd_valid, 0);
        ack_delay_cfg = 0;
        repeat (3) @(posedge i_clk);
        #1;
        $display("[TB] reset mid-read done");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
